// File: rtl/trace_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module      : trace_lockstep_checker
// Description : Compares a DUT event stream against a reference stream. Each
//               side is buffered in its own FIFO, so the two cores may drift
//               apart by up to DEPTH events. Heads are compared under the mask
//               stored with each DUT entry. The first error is latched, along
//               with a diagnostic snapshot of the heads.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_lockstep_checker #(
    parameter int DATA_WIDTH = 69,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      dut_valid,
    input  logic [DATA_WIDTH-1:0]     dut_data,
    input  logic [DATA_WIDTH-1:0]     dut_mask,
    input  logic                      ref_valid,
    input  logic [DATA_WIDTH-1:0]     ref_data,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [DATA_WIDTH-1:0]     err_dut_data,
    output logic [DATA_WIDTH-1:0]     err_ref_data,
    output logic [CNT_WIDTH-1:0]      match_count,
    output logic [$clog2(DEPTH):0]    dut_level,
    output logic [$clog2(DEPTH):0]    ref_level
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_PW    = c_AW + 1;
    localparam int c_TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [c_PW-1:0]    c_FULL     = c_PW'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit                 c_TMO_EN   = (TIMEOUT != 0);

    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_MISMATCH = 2'b01;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

    // Storage: DUT entries carry {data, mask}; reference entries carry data only
    logic [2*DATA_WIDTH-1:0] r_dut_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_ref_mem [DEPTH];

    // Pointers have one extra bit so a full FIFO is distinguishable from empty
    logic [c_PW-1:0]       r_dut_wptr;
    logic [c_PW-1:0]       r_dut_rptr;
    logic [c_PW-1:0]       r_ref_wptr;
    logic [c_PW-1:0]       r_ref_rptr;

    logic                  r_error;
    logic [1:0]            r_err_code;
    logic [DATA_WIDTH-1:0] r_err_dut_data;
    logic [DATA_WIDTH-1:0] r_err_ref_data;
    logic [CNT_WIDTH-1:0]  r_match_count;
    logic [c_TMO_W-1:0]    r_tmo_cnt;

    logic [c_PW-1:0]         w_dut_level;
    logic [c_PW-1:0]         w_ref_level;
    logic                    w_dut_empty;
    logic                    w_ref_empty;
    logic                    w_dut_full;
    logic                    w_ref_full;
    logic                    w_both_empty;
    logic                    w_one_busy;
    logic [2*DATA_WIDTH-1:0] w_dut_head;
    logic [DATA_WIDTH-1:0]   w_dut_head_data;
    logic [DATA_WIDTH-1:0]   w_dut_head_mask;
    logic [DATA_WIDTH-1:0]   w_ref_head;
    logic                    w_compare;
    logic                    w_mismatch;
    logic                    w_dut_push_req;
    logic                    w_ref_push_req;
    logic                    w_dut_overflow;
    logic                    w_ref_overflow;
    logic                    w_overflow;
    logic                    w_dut_push;
    logic                    w_ref_push;
    logic                    w_tmo_hit;

    // Occupancy uses modulo arithmetic on the extended pointers
    assign w_dut_level  = r_dut_wptr - r_dut_rptr;
    assign w_ref_level  = r_ref_wptr - r_ref_rptr;
    assign w_dut_empty  = (w_dut_level == '0);
    assign w_ref_empty  = (w_ref_level == '0);
    assign w_dut_full   = (w_dut_level == c_FULL);
    assign w_ref_full   = (w_ref_level == c_FULL);
    assign w_both_empty = w_dut_empty & w_ref_empty;
    assign w_one_busy   = w_dut_empty ^ w_ref_empty;

    assign w_dut_head      = r_dut_mem[r_dut_rptr[c_AW-1:0]];
    assign w_dut_head_data = w_dut_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_dut_head_mask = w_dut_head[DATA_WIDTH-1:0];
    assign w_ref_head      = r_ref_mem[r_ref_rptr[c_AW-1:0]];

    // A compare pops both heads, whether or not they match
    assign w_compare  = ~w_dut_empty & ~w_ref_empty & ~r_error;
    assign w_mismatch = w_compare & (|((w_dut_head_data ^ w_ref_head) & w_dut_head_mask));

    // A full FIFO still accepts a push when the same edge pops it
    assign w_dut_push_req = dut_valid & enable & ~r_error & ~clear;
    assign w_ref_push_req = ref_valid & enable & ~r_error & ~clear;
    assign w_dut_overflow = w_dut_push_req & w_dut_full & ~w_compare;
    assign w_ref_overflow = w_ref_push_req & w_ref_full & ~w_compare;
    assign w_overflow     = w_dut_overflow | w_ref_overflow;
    assign w_dut_push     = w_dut_push_req & ~w_dut_overflow;
    assign w_ref_push     = w_ref_push_req & ~w_ref_overflow;

    // Fires on the edge at which the one-sided wait count reaches TIMEOUT
    assign w_tmo_hit = c_TMO_EN & w_one_busy & ~r_error & (r_tmo_cnt == c_TMO_LAST);

    // Payload storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_dut_push) begin
            r_dut_mem[r_dut_wptr[c_AW-1:0]] <= {dut_data, dut_mask};
        end
        if (w_ref_push) begin
            r_ref_mem[r_ref_wptr[c_AW-1:0]] <= ref_data;
        end
    end

    // Pointers, first-error capture, match counter and one-sided wait timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dut_wptr     <= '0;
            r_dut_rptr     <= '0;
            r_ref_wptr     <= '0;
            r_ref_rptr     <= '0;
            r_error        <= 1'b0;
            r_err_code     <= c_ERR_NONE;
            r_err_dut_data <= '0;
            r_err_ref_data <= '0;
            r_match_count  <= '0;
            r_tmo_cnt      <= '0;
        end else if (clear) begin
            r_dut_wptr     <= '0;
            r_dut_rptr     <= '0;
            r_ref_wptr     <= '0;
            r_ref_rptr     <= '0;
            r_error        <= 1'b0;
            r_err_code     <= c_ERR_NONE;
            r_err_dut_data <= '0;
            r_err_ref_data <= '0;
            r_match_count  <= '0;
            r_tmo_cnt      <= '0;
        end else if (!r_error) begin
            if (w_dut_push) begin
                r_dut_wptr <= r_dut_wptr + 1'b1;
            end
            if (w_ref_push) begin
                r_ref_wptr <= r_ref_wptr + 1'b1;
            end
            if (w_compare) begin
                r_dut_rptr <= r_dut_rptr + 1'b1;
                r_ref_rptr <= r_ref_rptr + 1'b1;
            end

            // Mismatch outranks overflow, which outranks timeout
            if (w_mismatch) begin
                r_error        <= 1'b1;
                r_err_code     <= c_ERR_MISMATCH;
                r_err_dut_data <= w_dut_head_data;
                r_err_ref_data <= w_ref_head;
            end else if (w_overflow) begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_OVERFLOW;
            end else if (w_tmo_hit) begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_TIMEOUT;
            end

            if (w_compare && !w_mismatch && (r_match_count != {CNT_WIDTH{1'b1}})) begin
                r_match_count <= r_match_count + 1'b1;
            end

            if (w_compare || w_both_empty) begin
                r_tmo_cnt <= '0;
            end else if (c_TMO_EN) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign error        = r_error;
    assign err_code     = r_err_code;
    assign err_dut_data = r_err_dut_data;
    assign err_ref_data = r_err_ref_data;
    assign match_count  = r_match_count;
    assign dut_level    = w_dut_level;
    assign ref_level    = w_ref_level;

endmodule
`default_nettype wire

// File: tb/tb_trace_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_lockstep_checker
// Description : Self-checking bench for trace_lockstep_checker, with directed
//               scenarios and a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_lockstep_checker;

    localparam int DW      = 69;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = 32;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          clear;
    logic          dut_valid;
    logic [DW-1:0] dut_data;
    logic [DW-1:0] dut_mask;
    logic          ref_valid;
    logic [DW-1:0] ref_data;
    logic          error;
    logic [1:0]    err_code;
    logic [DW-1:0] err_dut_data;
    logic [DW-1:0] err_ref_data;
    logic [CW-1:0] match_count;
    logic [LW-1:0] dut_level;
    logic [LW-1:0] ref_level;

    int total;
    int bad;

    trace_lockstep_checker #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .dut_valid    (dut_valid),
        .dut_data     (dut_data),
        .dut_mask     (dut_mask),
        .ref_valid    (ref_valid),
        .ref_data     (ref_data),
        .error        (error),
        .err_code     (err_code),
        .err_dut_data (err_dut_data),
        .err_ref_data (err_ref_data),
        .match_count  (match_count),
        .dut_level    (dut_level),
        .ref_level    (ref_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] m_dq[$];
    logic [DW-1:0] m_dm[$];
    logic [DW-1:0] m_rq[$];
    bit            m_error;
    logic [1:0]    m_code;
    logic [DW-1:0] m_edd;
    logic [DW-1:0] m_erd;
    int unsigned   m_mc;
    int            m_wait;

    task automatic model_reset();
        m_dq.delete();
        m_dm.delete();
        m_rq.delete();
        m_error = 0;
        m_code  = 2'd0;
        m_edd   = '0;
        m_erd   = '0;
        m_mc    = 0;
        m_wait  = 0;
    endtask

    task automatic model_step();
        int            dsz;
        int            rsz;
        bit            both;
        bit            mism;
        bit            dovf;
        bit            rovf;
        bit            lone;
        bit            fire;
        logic [DW-1:0] dh;
        logic [DW-1:0] dm;
        logic [DW-1:0] rh;
        dsz  = m_dq.size();
        rsz  = m_rq.size();
        both = (dsz > 0) && (rsz > 0);
        lone = (dsz > 0) != (rsz > 0);
        mism = 0;
        dh   = '0;
        rh   = '0;
        if (both) begin
            dh = m_dq.pop_front();
            dm = m_dm.pop_front();
            rh = m_rq.pop_front();
            mism = (((dh ^ rh) & dm) != '0);
        end
        dovf = dut_valid && enable && (dsz == DEPTH) && !both;
        rovf = ref_valid && enable && (rsz == DEPTH) && !both;
        if (dut_valid && enable && !dovf) begin
            m_dq.push_back(dut_data);
            m_dm.push_back(dut_mask);
        end
        if (ref_valid && enable && !rovf) m_rq.push_back(ref_data);
        fire = (TIMEOUT > 0) && lone && (m_wait + 1 >= TIMEOUT);
        if (mism) begin
            m_error = 1; m_code = 2'd1; m_edd = dh; m_erd = rh;
        end else if (dovf || rovf) begin
            m_error = 1; m_code = 2'd2;
        end else if (fire) begin
            m_error = 1; m_code = 2'd3;
        end
        if (both && !mism && m_mc != 32'hFFFF_FFFF) m_mc++;
        if (lone) m_wait++;
        else m_wait = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else if (clear) model_reset();
        else if (!m_error) model_step();
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic idle();
        dut_valid = 0;
        ref_valid = 0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        #2 rst = 0;
        repeat (2) @(negedge clk);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %0b expected 0", error); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_code: got %0b expected 00", err_code); end
        total++; if (err_dut_data !== '0) begin bad++; $display("FAIL reset_edd: got %0h expected 0", err_dut_data); end
        total++; if (err_ref_data !== '0) begin bad++; $display("FAIL reset_erd: got %0h expected 0", err_ref_data); end
        total++; if (match_count !== '0) begin bad++; $display("FAIL reset_mc: got %0d expected 0", match_count); end
        total++; if (dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL reset_levels: got %0d/%0d expected 0/0", dut_level, ref_level); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_lockstep();
        logic [DW-1:0] d;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            d = rnd_word();
            dut_valid = 1; dut_data = d; dut_mask = '1;
            ref_valid = 1; ref_data = d;
            @(negedge clk);
            total++; if (dut_level !== LW'(m_dq.size())) begin bad++; $display("FAIL lockstep_level: got %0d expected %0d", dut_level, m_dq.size()); end
        end
        idle();
        @(negedge clk);
        total++; if (match_count !== 32'd20) begin bad++; $display("FAIL lockstep_mc: got %0d expected 20", match_count); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL lockstep_error: got %0b expected 0", error); end
        total++; if (dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL lockstep_levels: got %0d/%0d expected 0/0", dut_level, ref_level); end
    endtask

    task automatic test_skew();
        logic [DW-1:0] ev [8];
        int            peak;
        do_clear();
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            ev[i] = rnd_word();
            dut_valid = 1; dut_data = ev[i]; dut_mask = '1;
            @(negedge clk);
            if (int'(dut_level) > peak) peak = int'(dut_level);
        end
        dut_valid = 0;
        for (int i = 0; i < 8; i++) begin
            ref_valid = 1; ref_data = ev[i];
            @(negedge clk);
            if (int'(dut_level) > peak) peak = int'(dut_level);
        end
        idle();
        repeat (2) @(negedge clk);
        total++; if (peak !== 8) begin bad++; $display("FAIL skew_peak: got %0d expected 8", peak); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL skew_error: got %0b code %0b expected 0", error, err_code); end
        total++; if (match_count !== 32'd8) begin bad++; $display("FAIL skew_mc: got %0d expected 8", match_count); end
        total++; if (dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL skew_levels: got %0d/%0d expected 0/0", dut_level, ref_level); end
    endtask

    task automatic test_mask();
        logic [DW-1:0] d;
        logic [DW-1:0] r;
        logic [DW-1:0] m;
        do_clear();
        d = rnd_word();
        r = d;
        r[0] = ~r[0];
        m = '1;
        m[0] = 1'b0;
        dut_valid = 1; dut_data = d; dut_mask = m;
        ref_valid = 1; ref_data = r;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (error !== 1'b0 || match_count !== 32'd1) begin bad++; $display("FAIL mask_off: got err %0b mc %0d expected 0/1", error, match_count); end
        dut_valid = 1; dut_data = d; dut_mask = '1;
        ref_valid = 1; ref_data = r;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (err_code !== 2'b01 || error !== 1'b1) begin bad++; $display("FAIL mask_on_code: got %0b/%0b expected 1/01", error, err_code); end
        total++; if (err_dut_data !== d) begin bad++; $display("FAIL mask_edd: got %0h expected %0h", err_dut_data, d); end
        total++; if (err_ref_data !== r) begin bad++; $display("FAIL mask_erd: got %0h expected %0h", err_ref_data, r); end
        total++; if (match_count !== 32'd1) begin bad++; $display("FAIL mask_mc: got %0d expected 1", match_count); end
        for (int i = 0; i < 3; i++) begin
            dut_valid = 1; dut_data = d; dut_mask = '1;
            ref_valid = 1; ref_data = d;
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        total++; if (match_count !== 32'd1 || dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL mask_frozen: got mc %0d lv %0d/%0d expected 1 0/0", match_count, dut_level, ref_level); end
        total++; if (err_dut_data !== d || err_code !== 2'b01) begin bad++; $display("FAIL mask_hold: got %0h/%0b expected %0h/01", err_dut_data, err_code, d); end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 9; i++) begin
            dut_valid = 1; dut_data = rnd_word(); dut_mask = '1;
            @(negedge clk);
            if (i == 7) begin
                total++; if (error !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0b expected 0", error); end
            end
        end
        idle();
        total++; if (err_code !== 2'b10 || error !== 1'b1) begin bad++; $display("FAIL ovf_code: got %0b/%0b expected 1/10", error, err_code); end
        total++; if (dut_level !== LW'(8)) begin bad++; $display("FAIL ovf_level: got %0d expected 8", dut_level); end
        total++; if (err_dut_data !== '0 || err_ref_data !== '0) begin bad++; $display("FAIL ovf_data: got %0h/%0h expected 0/0", err_dut_data, err_ref_data); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] d;
        int            n;
        do_clear();
        d = rnd_word();
        dut_valid = 1; dut_data = d; dut_mask = '1;
        @(negedge clk);
        idle();
        n = 0;
        while (n < 40 && error !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== TIMEOUT) begin bad++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TIMEOUT); end
        total++; if (err_code !== 2'b11) begin bad++; $display("FAIL tmo_code: got %0b expected 11", err_code); end
        do_clear();
        dut_valid = 1; dut_data = d; dut_mask = '1;
        @(negedge clk);
        idle();
        repeat (9) @(negedge clk);
        ref_valid = 1; ref_data = d;
        @(negedge clk);
        idle();
        repeat (30) @(negedge clk);
        total++; if (error !== 1'b0 || match_count !== 32'd1) begin bad++; $display("FAIL tmo_late_ref: got err %0b mc %0d expected 0/1", error, match_count); end
    endtask

    task automatic test_clear();
        logic [DW-1:0] d;
        do_clear();
        d = rnd_word();
        dut_valid = 1; dut_data = d; dut_mask = '1;
        ref_valid = 1; ref_data = d;
        @(negedge clk);
        ref_data = ~d;
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (error !== 1'b1 || match_count !== 32'd1) begin bad++; $display("FAIL clear_pre: got err %0b mc %0d expected 1/1", error, match_count); end
        clear = 1;
        dut_valid = 1; dut_data = d; dut_mask = '1;
        @(negedge clk);
        clear = 0;
        idle();
        total++; if (error !== 1'b0 || err_code !== 2'b00) begin bad++; $display("FAIL clear_err: got %0b/%0b expected 0/00", error, err_code); end
        total++; if (err_dut_data !== '0 || err_ref_data !== '0) begin bad++; $display("FAIL clear_data: got %0h/%0h expected 0/0", err_dut_data, err_ref_data); end
        total++; if (match_count !== '0) begin bad++; $display("FAIL clear_mc: got %0d expected 0", match_count); end
        @(negedge clk);
        total++; if (dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL clear_drop: got %0d/%0d expected 0/0", dut_level, ref_level); end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] d;
        do_clear();
        d = rnd_word();
        dut_valid = 1; dut_data = d; dut_mask = '1;
        ref_valid = 1; ref_data = d;
        @(negedge clk);
        ref_valid = 0;
        dut_data = rnd_word();
        @(negedge clk);
        dut_data = rnd_word();
        @(negedge clk);
        total++; if (match_count !== 32'd1 || dut_level !== LW'(2)) begin bad++; $display("FAIL arst_pre: got mc %0d lv %0d expected 1/2", match_count, dut_level); end
        #2 rst = 0;
        #1;
        total++; if (match_count !== '0 || dut_level !== '0 || ref_level !== '0) begin bad++; $display("FAIL arst_async: got mc %0d lv %0d/%0d expected 0 0/0", match_count, dut_level, ref_level); end
        total++; if (error !== 1'b0 || err_code !== 2'b00) begin bad++; $display("FAIL arst_err: got %0b/%0b expected 0/00", error, err_code); end
        idle();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        total++; if (dut_level !== '0 || match_count !== '0) begin bad++; $display("FAIL arst_after: got lv %0d mc %0d expected 0/0", dut_level, match_count); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ev [64];
        int            di;
        int            ri;
        int            pd;
        int            pr;
        for (int i = 0; i < 64; i++) ev[i] = rnd_word();
        do_clear();
        di = 0;
        ri = 0;
        for (int seg = 0; seg < 20; seg++) begin
            pd = $urandom_range(0, 100);
            pr = $urandom_range(0, 100);
            for (int c = 0; c < 100; c++) begin
                if (error === 1'b1 || $urandom_range(0, 199) == 0) begin
                    clear = 1; idle(); enable = 1;
                    di = 0; ri = 0;
                end else begin
                    clear = 0;
                    enable = ($urandom_range(0, 9) != 0);
                    dut_valid = ($urandom_range(0, 99) < pd);
                    ref_valid = ($urandom_range(0, 99) < pr);
                    dut_data = ev[di % 64];
                    dut_mask = ($urandom_range(0, 3) == 0) ? rnd_word() : '1;
                    ref_data = ev[ri % 64];
                    if ($urandom_range(0, 49) == 0) ref_data[$urandom_range(0, DW - 1)] ^= 1'b1;
                    if (dut_valid && enable) di++;
                    if (ref_valid && enable) ri++;
                end
                @(negedge clk);
                total++; if (error !== m_error) begin bad++; $display("FAIL rnd_error: got %0b expected %0b", error, m_error); end
                total++; if (err_code !== m_code) begin bad++; $display("FAIL rnd_code: got %0b expected %0b", err_code, m_code); end
                total++; if (err_dut_data !== m_edd) begin bad++; $display("FAIL rnd_edd: got %0h expected %0h", err_dut_data, m_edd); end
                total++; if (err_ref_data !== m_erd) begin bad++; $display("FAIL rnd_erd: got %0h expected %0h", err_ref_data, m_erd); end
                total++; if (match_count !== m_mc) begin bad++; $display("FAIL rnd_mc: got %0d expected %0d", match_count, m_mc); end
                total++; if (dut_level !== LW'(m_dq.size())) begin bad++; $display("FAIL rnd_dlevel: got %0d expected %0d", dut_level, m_dq.size()); end
                total++; if (ref_level !== LW'(m_rq.size())) begin bad++; $display("FAIL rnd_rlevel: got %0d expected %0d", ref_level, m_rq.size()); end
            end
        end
        clear = 0;
        enable = 1;
        idle();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1;
        enable    = 1;
        clear     = 0;
        dut_valid = 0;
        dut_data  = '0;
        dut_mask  = '1;
        ref_valid = 0;
        ref_data  = '0;
        test_reset();
        test_lockstep();
        test_skew();
        test_mask();
        test_overflow();
        test_timeout();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_lockstep_checker.md
Name: trace_lockstep_checker

Overview:
Parametrised successor to the fixed, same-cycle DUT-vs-golden trace comparison in the emulation top. It takes two independent event streams, DUT and reference, each with its own valid/data. Each stream is buffered in a per-side FIFO so the two cores may retire the same event up to DEPTH entries apart. Heads are compared under a per-event mask, and the block latches the first error with a diagnostic snapshot. It sits in the emulation top beside custom_cpu and custom_cpu_golden, fed by their retire/trace buses, and drives an EmuTrigger.

Parameters:
DATA_WIDTH, 69, width of one trace event.
DEPTH, 8, entries per side FIFO; power of two, minimum 2.
TIMEOUT, 1024, maximum cycles one side may hold entries while the other is empty; 0 disables the timeout check.
CNT_WIDTH, 32, width of match_count.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset.
enable  in  1  push enable for both sides; compares continue while low.
clear  in  1  synchronous flush of FIFOs, error state and counters.
dut_valid  in  1  DUT event strobe.
dut_data  in  DATA_WIDTH  DUT event payload.
dut_mask  in  DATA_WIDTH  per-bit compare mask; 1 = compare. Stored with the DUT entry.
ref_valid  in  1  reference event strobe.
ref_data  in  DATA_WIDTH  reference event payload.
error  out  1  sticky; high once any error is latched.
err_code  out  2  00 none, 01 data mismatch, 10 overflow, 11 timeout.
err_dut_data  out  DATA_WIDTH  DUT head at the mismatch; 0 for other error types.
err_ref_data  out  DATA_WIDTH  reference head at the mismatch; 0 for other error types.
match_count  out  CNT_WIDTH  number of matched compares.
dut_level  out  log2(DEPTH)+1  DUT FIFO occupancy.
ref_level  out  log2(DEPTH)+1  reference FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous): FIFOs empty; error=0; err_code=00; err_dut_data=0; err_ref_data=0; match_count=0; levels=0; timeout counter=0.
- Push: a side pushes on a clock edge when valid & enable & !error & !clear.
  - An entry pushed at edge t is at its head from cycle t+1.
  - The DUT entry stores {dut_data, dut_mask}.
- Compare: happens in any cycle where both FIFOs are non-empty and !error.
  - Both heads pop at that edge.
  - Match when ((dut_head ^ ref_head) & mask_head) == 0.
  - Compare is combinational on the heads; results are registered.
  - Both streams valid in cycle t produce a compare in cycle t+1, with error/match_count visible at t+2.
- Match: match_count increments and saturates at all ones.
- Mismatch: err_code=01, error=1, both heads captured into err_dut_data/err_ref_data.
- Full:
  - A push to a full FIFO with a pop on the same edge is accepted.
  - A push to a full FIFO without a pop is an overflow: err_code=10 and the event is dropped.
- Timeout:
  - The counter increments each cycle exactly one FIFO is non-empty.
  - It resets to 0 on any compare, or when both FIFOs are empty.
  - Reaching TIMEOUT latches err_code=11.
  - TIMEOUT=0 never fires.
- Simultaneous errors in one cycle: priority is mismatch, then overflow, then timeout.
- First error wins. After error=1:
  - no pushes, pops or compares;
  - FIFOs, levels and match_count freeze;
  - err_* outputs hold until clear or reset.
- clear=1:
  - next edge empties FIFOs and zeroes error, err_code, err_*_data, match_count and the timeout counter;
  - pushes in the same cycle are discarded;
  - clear has priority over every other event.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits wide (extra bit distinguishes full from empty); level = wptr - rptr, modulo arithmetic.
- Reset mid-operation: all state returns to reset values immediately, with no partial compare.

Test Plan:
- Lockstep match: 20 identical events on both sides, same cycles, mask all ones -> match_count=20, error=0, both levels 0 two cycles after the last event.
- Skewed match: DUT sends 8 events, then ref sends the same 8 (DEPTH=8) -> dut_level peaks at 8, no overflow, match_count=8.
- Masked compare: bit0 differs, with mask bit0=0 -> match. Same event with mask bit0=1 -> err_code=01, err_dut_data and err_ref_data equal the two payloads, match_count frozen.
- Overflow: DUT pushes 9 events with ref idle, DEPTH=8 -> err_code=10 on the 9th push, dut_level=8.
- Timeout: TIMEOUT=16, one DUT event and no ref event -> err_code=11 at 16 cycles after the entry reaches the head; a ref event arriving at cycle 10 instead gives no error.
- Clear/reset: after an error, pulse clear together with dut_valid -> everything zero, pushed event dropped. Assert rst low mid-stream -> outputs zero asynchronously, before the next edge.
